// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone B3 burst RAM slave.
//   - CTI_* : cycle type identifiers (classic, incrementing burst, end of burst)
//   - BTE_* : burst type extensions (linear, wrap4, wrap8, wrap16)
//   - state_t : slave FSM state encoding
//   - wrap_bits() : number of low word-address bits that wrap for a given BTE
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StBurst
  } state_t;

  // 0 means "no wrap": the whole word index increments.
  function automatic int unsigned wrap_bits(input logic [1:0] bte);
    int unsigned bits;
    case (bte)
      BTE_WRAP4:  bits = 2;
      BTE_WRAP8:  bits = 3;
      BTE_WRAP16: bits = 4;
      default:    bits = 0;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/wb_ram_burst_mem.sv
// Storage array for wb_ram_burst: DEPTH x DW words, one write port with
// per-byte enables and one registered read port.
//   clk      clock
//   rst      synchronous reset, active high; clears the read register only
//   wr_en    write strobe
//   wr_addr  write word index
//   wr_data  write data
//   wr_sel   byte-lane enables for the write
//   rd_en    load the read register from rd_addr (holds otherwise)
//   rd_addr  read word index
//   rd_data  registered read data
// A read and a write to the same word on one edge returns the old contents.
module wb_ram_burst_mem #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_sel,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data
);

  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < SW; k++) begin
        if (wr_sel[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B3 RAM slave with registered-feedback incrementing bursts.
// Optional feature macro: WB_RAM_ERR_EN (out-of-range addresses answer with
// err_o instead of ack_o and suppress the write; default build ties err_o low
// and lets upper address bits alias).
//   clk_i  clock               rst_i  synchronous reset, active high
//   adr_i  byte address        dat_i  write data       sel_i  byte lanes
//   we_i   1 = write           cyc_i  bus cycle        stb_i  strobe
//   cti_i  cycle type          bte_i  burst type
//   ack_o  acknowledge         err_o  error            dat_o  read data
module wb_ram_burst
  import wb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 9,
  parameter int unsigned ADR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DW-1:0]     dat_i,
  input  logic [DW/8-1:0]   sel_i,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [2:0]        cti_i,
  input  logic [1:0]        bte_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [DW-1:0]     dat_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned OFF = $clog2(SW);

  state_t        state;
  logic          ack;
  logic          err;
  logic [AW-1:0] cur;

  logic [AW-1:0] adr_word;
  logic          req;
  logic          addr_bad;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] inc;
  logic [AW-1:0] nxt;
  logic          go_first;
  logic          go_next;
  logic          issue;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          wr_en;
  logic          unused_adr;

  assign adr_word   = adr_i[AW+OFF-1:OFF];
  assign req        = cyc_i & stb_i;
  assign unused_adr = ^adr_i;

`ifdef WB_RAM_ERR_EN
  assign addr_bad = |adr_i[ADR_W-1:AW+OFF];
`else
  assign addr_bad = 1'b0;
`endif

  // Next burst word: the masked low bits count, the rest hold.
  always_comb begin
    if (bte_i == BTE_LINEAR) begin
      wrap_mask = '1;
    end else begin
      wrap_mask = AW'((32'd1 << wrap_bits(bte_i)) - 32'd1);
    end
    inc = cur + AW'(1);
    nxt = (cur & ~wrap_mask) | (inc & wrap_mask);
  end

  // First access comes from adr_i; a continuing beat is only issued while the
  // current beat is being acked with cti = incrementing, so the read for the
  // following word is already in flight when the master samples this ack.
  assign go_first = (state == StIdle) & req;
  assign go_next  = (state != StIdle) & req & ack & (cti_i == CTI_INCR);
  assign issue    = go_first | go_next;
  assign rd_addr  = go_first ? adr_word : nxt;
  assign rd_en    = issue & ~addr_bad & ~rst_i;

  // Write lands at the end of the ack cycle; a stale ack with stb low is ignored.
  assign wr_en = ack & req & we_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= StIdle;
      ack   <= 1'b0;
      err   <= 1'b0;
      cur   <= '0;
    end else begin
      ack <= issue & ~addr_bad;
      err <= issue & addr_bad;
      if (issue) begin
        cur <= rd_addr;
      end
      unique case (state)
        StIdle:         if (go_first) state <= StAck;
        StAck, StBurst: state <= go_next ? StBurst : StIdle;
        default:        state <= StIdle;
      endcase
    end
  end

  assign ack_o = ack;
  assign err_o = err;

  wb_ram_burst_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (wr_en),
    .wr_addr (adr_word),
    .wr_data (dat_i),
    .wr_sel  (sel_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (dat_o)
  );

endmodule

// File: tb/tb_wb_ram_burst.sv
// Self-checking bench for wb_ram_burst (DW=32, AW=9, ADR_W=32).
module tb_wb_ram_burst;
  import wb_pkg::*;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;

  always #5 clk = ~clk;

  wb_ram_burst #(
    .DW    (32),
    .AW    (9),
    .ADR_W (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .adr_i (adr),
    .dat_i (dat_w),
    .sel_i (sel),
    .we_i  (we),
    .cyc_i (cyc),
    .stb_i (stb),
    .cti_i (cti),
    .bte_i (bte),
    .ack_o (ack),
    .err_o (err),
    .dat_o (dat_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word order of a burst, from the cti/bte rules.
  function automatic int next_word(input int w, input logic [1:0] b);
    int n;
    case (b)
      2'b00:   return (w + 1) % DEPTH;
      2'b01:   n = 4;
      2'b10:   n = 8;
      default: n = 16;
    endcase
    return (w - (w % n)) + ((w % n) + 1) % n;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  logic        e_ack = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_dat = '0;
  bit          e_known = 1'b0;
  bit          chk_en = 1'b0;
  int          beat_word = 0;

  initial for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;

  always @(posedge clk) begin : model
    bit          rq, resp, bad, rk;
    int          word, wword;
    logic [31:0] rd;
    rq  = cyc && stb;
    bad = 1'b0;
`ifdef WB_RAM_ERR_EN
    bad = (adr >> 11) != 0;
`endif
    if (rst) begin
      e_ack = 1'b0; e_err = 1'b0; e_dat = '0; e_known = 1'b1; chk_en = 1'b1;
    end else begin
      resp = rq && (!(e_ack || e_err) || (e_ack && cti == CTI_INCR));
      word = e_ack ? next_word(beat_word, bte) : int'(adr[10:2]);
      rd   = mmem[word];
      rk   = mknown[word];
      if (e_ack && rq && we) begin
        wword = int'(adr[10:2]);
        for (int k = 0; k < 4; k++) if (sel[k]) mmem[wword][8*k +: 8] = dat_w[8*k +: 8];
        if (sel == 4'hF) mknown[wword] = 1'b1;
      end
      if (resp) begin
        beat_word = word;
        if (bad) begin
          e_ack = 1'b0; e_err = 1'b1;
        end else begin
          e_ack = 1'b1; e_err = 1'b0; e_dat = rd; e_known = rk;
        end
      end else begin
        e_ack = 1'b0; e_err = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("ack_vs_model", {31'b0, ack}, {31'b0, e_ack});
      check("err_vs_model", {31'b0, err}, {31'b0, e_err});
      if (e_known) check("dat_vs_model", dat_r, e_dat);
    end
  end

  // ---------------- bus master tasks ----------------
  logic [31:0] rd_q [$];

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    sel = 4'h0; adr = '0; dat_w = '0;
  endtask

  task automatic classic(input logic [31:0] a, input bit wr, input logic [31:0] d,
                         input logic [3:0] s, output bit got_ack, output bit got_err,
                         output logic [31:0] rdat, output int lat, output bit ack_after);
    bit done;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s; cti = CTI_CLASSIC;
    lat = 0; done = 1'b0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
    while (!done && lat < 10) begin
      @(negedge clk);
      if (ack || err) begin
        done = 1'b1; got_ack = ack; got_err = err; rdat = dat_r;
      end else begin
        lat++;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    ack_after = ack;
  endtask

  // mode 0: complete burst of n beats; after `stop` beats mode 1 drops stb,
  // mode 2 drops cyc, mode 3 pulses rst.
  task automatic burst(input int start, input logic [1:0] b, input int n, input bit wr,
                       input int mode, input int stop, output int lat, output int gaps,
                       output bit tail_ack, output logic [31:0] tail_dat);
    int w, beats;
    bit ok;
    rd_q.delete();
    gaps = 0; tail_ack = 1'b0; tail_dat = '0;
    @(posedge clk); #1;
    w = start;
    cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; bte = b;
    adr = 32'(w) << 2; dat_w = 32'(w); cti = (n == 1) ? CTI_EOB : CTI_INCR;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 10) begin
      @(negedge clk);
      if (ack) ok = 1'b1;
      else lat++;
    end
    if (!ok) begin
      bus_idle();
      return;
    end
    beats = (mode == 0) ? n : stop;
    for (int i = 0; i < beats; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (!ack) begin
          gaps++;
          break;
        end
      end
      rd_q.push_back(dat_r);
      @(posedge clk); #1;
      if (i == beats - 1) begin
        case (mode)
          0:       bus_idle();
          1:       stb = 1'b0;
          2:       begin cyc = 1'b0; stb = 1'b0; end
          default: begin rst = 1'b1; bus_idle(); end
        endcase
      end else begin
        w = next_word(w, b);
        adr = 32'(w) << 2; dat_w = 32'(w);
        cti = (i + 1 == n - 1) ? CTI_EOB : CTI_INCR;
      end
    end
    if (gaps != 0) begin
      bus_idle();
      return;
    end
    if (mode != 0) begin
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_idle();
    end
    @(negedge clk);
    tail_ack = ack;
    tail_dat = dat_r;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    bit          ga, ge, aa, ta;
    logic [31:0] rv, td;
    int          lat, gaps;

    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_dat", dat_r, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Classic write then read back.
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, ga, ge, rv, lat, aa);
    check("cw_latency", 32'(lat), 32'd1);
    check("cw_ack", {31'b0, ga}, 32'd1);
    classic(32'h10, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
    check("cr_latency", 32'(lat), 32'd1);
    check("cr_data", rv, 32'hDEADBEEF);
    check("cr_ack_low_after", {31'b0, aa}, 32'd0);

    // Byte lanes.
    classic(32'h20, 1'b1, 32'h11223344, 4'hF, ga, ge, rv, lat, aa);
    classic(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, ga, ge, rv, lat, aa);
    classic(32'h20, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
    check("lane_data", rv, 32'h11BB33DD);

    // Fill words 0..31 with their own index by a linear write burst.
    burst(0, BTE_LINEAR, 32, 1'b1, 0, 0, lat, gaps, ta, td);
    check("fill_latency", 32'(lat), 32'd1);
    check("fill_gaps", 32'(gaps), 32'd0);

    // Linear read burst of 8.
    burst(0, BTE_LINEAR, 8, 1'b0, 0, 0, lat, gaps, ta, td);
    check("lin_latency", 32'(lat), 32'd1);
    check("lin_gaps", 32'(gaps), 32'd0);
    check("lin_beats", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < rd_q.size(); i++) check("lin_data", rd_q[i], 32'(i));
    check("lin_tail_ack", {31'b0, ta}, 32'd0);

    // Wrap4 from word 6: 6,7,4,5.
    burst(6, BTE_WRAP4, 4, 1'b0, 0, 0, lat, gaps, ta, td);
    check("w4_beats", 32'(rd_q.size()), 32'd4);
    if (rd_q.size() == 4) begin
      check("w4_d0", rd_q[0], 32'd6);
      check("w4_d1", rd_q[1], 32'd7);
      check("w4_d2", rd_q[2], 32'd4);
      check("w4_d3", rd_q[3], 32'd5);
    end

    // Wrap16 from word 0x1F: 0x1F, 0x10..0x1E.
    burst(32'h1F, BTE_WRAP16, 16, 1'b0, 0, 0, lat, gaps, ta, td);
    check("w16_beats", 32'(rd_q.size()), 32'd16);
    for (int i = 0; i < rd_q.size(); i++)
      check("w16_data", rd_q[i], (i == 0) ? 32'h1F : 32'h10 + 32'(i - 1));

    // stb dropped after the 2nd beat, then restart where it left off.
    burst(6, BTE_WRAP4, 4, 1'b0, 1, 2, lat, gaps, ta, td);
    check("stbdrop_beats", 32'(rd_q.size()), 32'd2);
    check("stbdrop_ack_after", {31'b0, ta}, 32'd0);
    burst(4, BTE_WRAP4, 2, 1'b0, 0, 0, lat, gaps, ta, td);
    check("restart_latency", 32'(lat), 32'd1);
    check("restart_beats", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() == 2) begin
      check("restart_d0", rd_q[0], 32'd4);
      check("restart_d1", rd_q[1], 32'd5);
    end

    // cyc dropped mid-burst.
    burst(8, BTE_LINEAR, 8, 1'b0, 2, 3, lat, gaps, ta, td);
    check("cycdrop_beats", 32'(rd_q.size()), 32'd3);
    check("cycdrop_ack_after", {31'b0, ta}, 32'd0);

    // Reset pulsed mid-burst.
    burst(16, BTE_LINEAR, 8, 1'b0, 3, 2, lat, gaps, ta, td);
    check("rst_ack_after", {31'b0, ta}, 32'd0);
    check("rst_dat_after", td, 32'd0);
    classic(32'h10, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
    check("reread_w4", rv, 32'd4);
    classic(32'h40, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
    check("reread_w16", rv, 32'd16);

    // Out-of-range byte address 0x800.
    classic(32'h800, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
`ifdef WB_RAM_ERR_EN
    check("oor_rd_ack", {31'b0, ga}, 32'd0);
    check("oor_rd_err", {31'b0, ge}, 32'd1);
`else
    check("alias_rd_ack", {31'b0, ga}, 32'd1);
    check("alias_rd_err", {31'b0, ge}, 32'd0);
    check("alias_rd_data", rv, 32'd0);
`endif
    classic(32'h800, 1'b1, 32'h5A5A5A5A, 4'hF, ga, ge, rv, lat, aa);
    classic(32'h0, 1'b0, 32'h0, 4'hF, ga, ge, rv, lat, aa);
`ifdef WB_RAM_ERR_EN
    check("oor_word0_intact", rv, 32'd0);
`else
    check("alias_word0_written", rv, 32'h5A5A5A5A);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
